// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream: N-to-1 valid/ready stream multiplexer.
// The channel is picked either by an external selector or by a round-robin
// scan that starts at a rotating pointer. The output is one registered
// valid/ready stage. It carries the source channel tag and a wrapping count
// of accepted input transfers.
module mux_nx1_stream #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     selector,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic [N-1:0]         valid_in,
    output logic [N-1:0]         ready_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [SEL_W-1:0]     chan_out,
    output logic [CNT_W-1:0]     xfer_count
);

    // Output stage and arbitration state.
    logic [WIDTH-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] chan_q,  chan_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;

    // Combinational helpers.
    logic             load_s;
    logic             cand_vld_s;
    logic [SEL_W-1:0] cand_s;
    logic [2*N-1:0]   valid_rot_s;
    int               rr_idx_s;
    logic [WIDTH-1:0] cand_data_s;
    logic             cand_valid_s;
    logic [SEL_W-1:0] cand_next_s;
    logic             xfer_s;

    // The output register can take a new word when it is empty or being drained.
    always_comb begin
        load_s = !valid_q || ready_out;
    end

    // Pick the candidate channel. Selector mode trusts the index if it is in range.
    // Round-robin rotates valid_in so that bit 0 is the pointer channel, then
    // takes the first set bit.
    always_comb begin
        cand_vld_s  = 1'b0;
        cand_s      = '0;
        rr_idx_s    = 0;
        valid_rot_s = {valid_in, valid_in} >> ptr_q;
        if (mode == 1'b0) begin
            if (int'(selector) < N) begin
                cand_vld_s = 1'b1;
                cand_s     = selector;
            end else begin
                cand_vld_s = 1'b0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!cand_vld_s && valid_rot_s[i]) begin
                    cand_vld_s = 1'b1;
                    rr_idx_s   = int'(ptr_q) + i;
                    if (rr_idx_s >= N) begin
                        rr_idx_s = rr_idx_s - N;
                    end else begin
                        rr_idx_s = rr_idx_s;
                    end
                    cand_s = SEL_W'(rr_idx_s);
                end else begin
                    cand_vld_s = cand_vld_s;
                end
            end
        end
    end

    // Fetch the candidate's data and valid and compute the following pointer value.
    // Drive ready_in toward the candidate only.
    always_comb begin
        cand_data_s  = '0;
        cand_valid_s = 1'b0;
        cand_next_s  = '0;
        ready_in     = '0;
        for (int k = 0; k < N; k++) begin
            if (cand_vld_s && (cand_s == SEL_W'(k))) begin
                cand_data_s  = data_in[k*WIDTH +: WIDTH];
                cand_valid_s = valid_in[k];
                cand_next_s  = (k == N - 1) ? '0 : SEL_W'(k + 1);
                ready_in[k]  = load_s && !reset;
            end else begin
                ready_in[k]  = 1'b0;
            end
        end
        xfer_s = cand_vld_s && cand_valid_s && load_s && !reset;
    end

    // Next-state logic for the output word, the counter and the round-robin pointer.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        chan_d  = chan_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        if (load_s) begin
            if (xfer_s) begin
                data_d  = cand_data_s;
                chan_d  = cand_s;
                valid_d = 1'b1;
                count_d = count_q + CNT_W'(1);
                if (mode == 1'b1) begin
                    ptr_d = cand_next_s;
                end else begin
                    ptr_d = ptr_q;
                end
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers with synchronous reset. Reset drops any held output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chan_q  <= '0;
            count_q <= '0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            chan_q  <= chan_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign chan_out   = chan_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Self-checking bench for mux_nx1_stream. A behavioural model is checked on
// every falling edge. Directed literal checks pin the model.
module tb_mux_nx1_stream;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic [SW-1:0] selector;
    logic [N*W-1:0] data_in;
    logic [N-1:0]  valid_in;
    logic [N-1:0]  ready_in;
    logic [W-1:0]  data_out;
    logic          valid_out;
    logic          ready_out;
    logic [SW-1:0] chan_out;
    logic [CW-1:0] xfer_count;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model state
    int m_data  = 0;
    int m_chan  = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;
    bit m_valid = 1'b0;

    mux_nx1_stream #(.N(N), .WIDTH(W), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .mode(mode), .selector(selector),
        .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .chan_out(chan_out), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Candidate channel from the current inputs, or -1 if there is none
    function automatic int pick();
        int c = -1;
        if (mode == 1'b0) begin
            if (int'(selector) < N) c = int'(selector);
        end else begin
            for (int s = 0; s < N; s++) begin
                int k;
                k = (m_ptr + s) % N;
                if (c < 0 && valid_in[k]) c = k;
            end
        end
        return c;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        int c = pick();
        if (!reset && c >= 0 && (!m_valid || ready_out)) r[c] = 1'b1;
        return r;
    endfunction

    // Model update at the active edge
    always @(posedge clk) begin
        int c;
        c = pick();
        if (reset) begin
            m_data <= 0; m_chan <= 0; m_cnt <= 0; m_ptr <= 0; m_valid <= 1'b0;
        end else if (!m_valid || ready_out) begin
            if (c >= 0 && valid_in[c]) begin
                m_data  <= int'(data_in[c*W +: W]);
                m_chan  <= c;
                m_valid <= 1'b1;
                m_cnt   <= (m_cnt + 1) % (1 << CW);
                if (mode) m_ptr <= (c + 1) % N;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_data_out",   32'(data_out),   32'(m_data));
            check("m_valid_out",  32'(valid_out),  32'(m_valid));
            check("m_chan_out",   32'(chan_out),   32'(m_chan));
            check("m_xfer_count", 32'(xfer_count), 32'(m_cnt));
            check("m_ready_in",   32'(ready_in),   32'(exp_ready()));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int sel_exp[4];
        int rr_exp[8];
        int alt_exp[4];
        sel_exp = '{1, 2, 3, 0};
        rr_exp  = '{0, 1, 2, 3, 0, 1, 2, 3};
        alt_exp = '{1, 3, 1, 3};

        // Reset and idle
        reset = 1'b1; mode = 1'b0; selector = '0; valid_in = 4'hF;
        ready_out = 1'b1; data_in = 16'h0321;
        #1 check("rst_ready", 32'(ready_in), 32'd0);
        step(1);
        chk_en = 1'b1;
        step(1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data",  32'(data_out),  32'd0);
        check("rst_cnt",   32'(xfer_count), 32'd0);
        reset = 1'b0;

        // Selector mode, stepping 0..3
        for (int i = 0; i < 4; i++) begin
            selector = SW'(i);
            step(1);
            check("sel_data",  32'(data_out),  32'(sel_exp[i]));
            check("sel_chan",  32'(chan_out),  32'(i));
            check("sel_valid", 32'(valid_out), 32'd1);
        end
        check("sel_cnt", 32'(xfer_count), 32'd4);

        // Backpressure holding data_out=2
        selector = 3'd1;
        step(1);
        check("bp_data0", 32'(data_out), 32'd2);
        ready_out = 1'b0; selector = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_ready", 32'(ready_in), 32'd0);
            step(1);
            check("bp_hold",  32'(data_out),  32'd2);
            check("bp_valid", 32'(valid_out), 32'd1);
        end
        check("bp_cnt_hold", 32'(xfer_count), 32'd5);
        ready_out = 1'b1;
        step(1);
        check("bp_release", 32'(data_out),   32'd3);
        check("bp_cnt",     32'(xfer_count), 32'd6);

        // Out-of-range selector, then an invalid selected channel
        selector = 3'd5;
        #1 check("inv_ready", 32'(ready_in), 32'd0);
        step(1);
        check("inv_valid", 32'(valid_out), 32'd0);
        check("inv_data",  32'(data_out),  32'd3);
        selector = 3'd0; valid_in = 4'b1110;
        #1 check("nv_ready", 32'(ready_in), 32'd1);
        step(1);
        check("nv_valid", 32'(valid_out), 32'd0);
        check("nv_cnt",   32'(xfer_count), 32'd6);

        // Round-robin fairness
        mode = 1'b1; valid_in = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("rr_chan", 32'(chan_out), 32'(rr_exp[i]));
        end
        check("rr_cnt", 32'(xfer_count), 32'd6);
        valid_in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("rr_alt", 32'(chan_out), 32'(alt_exp[i]));
        end
        check("rr_alt_cnt", 32'(xfer_count), 32'd2);
        valid_in = 4'b0000;
        #1 check("rr_empty_ready", 32'(ready_in), 32'd0);
        step(1);
        check("rr_empty_valid", 32'(valid_out), 32'd0);

        // Reset mid-stream while the output is stalled
        valid_in = 4'b0010;
        step(1);
        check("mid_chan", 32'(chan_out), 32'd1);
        ready_out = 1'b0; valid_in = 4'hF;
        step(1);
        check("mid_hold", 32'(valid_out), 32'd1);
        reset = 1'b1;
        #1 check("mid_rst_ready", 32'(ready_in), 32'd0);
        step(1);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_cnt",   32'(xfer_count), 32'd0);
        reset = 1'b0; ready_out = 1'b1;
        step(1);
        check("mid_ptr0", 32'(chan_out), 32'd0);

        // Counter wrap: 9 transfers since reset
        step(8);
        check("wrap_cnt",  32'(xfer_count), 32'd1);
        check("wrap_chan", 32'(chan_out),   32'd0);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
- Parametrised N-to-1 stream multiplexer; successor to the 2x1 4-bit valid mux.
- Selects one of N valid/data channels by external selector or by round-robin arbitration.
- Output is a registered valid/ready stage with backpressure toward the sources, plus channel tag and transfer counter.
- Sits between parallel lane sources and a single downstream consumer in the datapath.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 4, data width per channel.
- SEL_W, 2, selector/tag width; must satisfy 2**SEL_W >= N.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = selector mode, 1 = round-robin mode.
- selector  input  SEL_W  channel index used in selector mode.
- data_in  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- valid_in  input  N  per-channel valid.
- ready_in  output  N  per-channel ready, combinational.
- data_out  output  WIDTH  registered data.
- valid_out  output  1  registered valid.
- ready_out  input  1  downstream ready.
- chan_out  output  SEL_W  index of the channel that produced data_out.
- xfer_count  output  CNT_W  number of accepted input transfers, wraps modulo 2**CNT_W.

Behaviour:
- Reset (clk edge with reset=1): data_out=0, valid_out=0, chan_out=0, xfer_count=0, rr pointer ptr=0. ready_in=0 while reset=1.
- load = !valid_out || ready_out. The output register may accept new data only when load=1.
- Selector mode: cand = selector. If selector >= N, there is no candidate and all ready_in=0.
- Round-robin mode: cand is the first k with valid_in[k]=1, scanning ptr, ptr+1, ... and wrapping modulo N. If no channel is valid, there is no candidate.
- ready_in[cand] = load; every other ready_in bit = 0. ready_in never depends on valid_in of the same channel in selector mode.
- Transfer happens when load && valid_in[cand]. On the next edge: data_out = channel cand data, chan_out = cand, valid_out = 1, xfer_count += 1.
  - In round-robin mode only, ptr = (cand+1) mod N.
- If load=1 and there is no transfer: valid_out <= 0. data_out and chan_out hold their values.
- If load=0 (valid_out=1, ready_out=0): data_out, valid_out, chan_out, ptr and count all hold. No input is accepted.
- Latency: 1 cycle from the input handshake to valid_out. Full throughput: one word per cycle when ready_out is held at 1.
- ptr holds across mode changes and in selector mode. A mode change takes effect combinationally in the same cycle.
- Reset asserted mid-stream discards any held output word. No input is accepted during that cycle.
- xfer_count wraps from 2**CNT_W-1 to 0.

Test Plan:
- Reset/idle: reset=1 for 2 cycles with all valid_in=1 -> ready_in=0, valid_out=0, data_out=0, xfer_count=0; first edge after release with mode=0, selector=0, data ch0=1 -> data_out=1, chan_out=0, valid_out=1.
- Selector mode: mode=0, data = {ch0=1, ch1=2, ch2=3, ch3=0}, all valid, ready_out=1; step selector 0,1,2,3 -> data_out 1,2,3,0 one cycle later each; xfer_count=4.
- Round-robin fairness: mode=1, all four valid for 8 cycles -> chan_out sequence 0,1,2,3,0,1,2,3; with only ch1 and ch3 valid -> 1,3,1,3.
- Backpressure: hold ready_out=0 after data_out=2 -> all ready_in=0 and data_out stays 2 for 3 cycles; on release the next word appears one cycle later, with no loss or duplication (count +1 per handshake).
- Invalid/empty: selector=5 with N=4, or all valid_in=0 -> ready_in=0 and valid_out drops to 0 while data_out holds its last value; valid_in=0 on the selected channel -> valid_out=0.
- Reset mid-operation and wrap: assert reset with valid_out=1, ready_out=0 -> valid_out=0 and ptr=0 next cycle; with CNT_W=3, 9 transfers -> xfer_count=1.
